// File: rtl/iir_biquad_seq_pkg.sv
// Shared types and constants for the sequential biquad IIR filter.
package iir_biquad_seq_pkg;

  localparam int DEF_A_WIDTH = 7;
  localparam int DEF_B_WIDTH = 6;
  localparam int ACC_WIDTH   = DEF_A_WIDTH + DEF_B_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  localparam logic [2:0] TAP_B0  = 3'd0;
  localparam logic [2:0] TAP_B1  = 3'd1;
  localparam logic [2:0] TAP_B2  = 3'd2;
  localparam logic [2:0] TAP_FB1 = 3'd3;
  localparam logic [2:0] TAP_FB2 = 3'd4;

endpackage

// File: rtl/multaddsub_add_sign_7_6.sv
// Combinational signed multiply-add: c = a*b + din, wrapping at C_W bits.
module multaddsub_add_sign_7_6
  import iir_biquad_seq_pkg::*;
#(
  parameter int A_W = DEF_A_WIDTH,
  parameter int B_W = DEF_B_WIDTH,
  parameter int C_W = ACC_WIDTH
) (
  input  logic signed [A_W-1:0] a,
  input  logic signed [B_W-1:0] b,
  input  logic signed [C_W-1:0] din,
  output logic signed [C_W-1:0] c
);

  assign c = C_W'(a) * C_W'(b) + din;

endmodule

// File: rtl/iir_biquad_seq.sv
// Sequential biquad IIR: one multiply-add per cycle over five taps.
// Optional output saturation enabled by defining IIR_SAT_EN (default: wrap).
//
// state   | meaning
// IDLE    | waiting for an input sample, in_ready high
// MAC     | accumulating taps 0..4, one product per cycle
// OUT     | presenting out_sample until out_ready
module iir_biquad_seq
  import iir_biquad_seq_pkg::*;
#(
  parameter int A_WIDTH    = DEF_A_WIDTH,
  parameter int B_WIDTH    = DEF_B_WIDTH,
  parameter int FRAC_SHIFT = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [A_WIDTH-1:0]  in_sample,
  input  logic signed [B_WIDTH-1:0]  coef_b0,
  input  logic signed [B_WIDTH-1:0]  coef_b1,
  input  logic signed [B_WIDTH-1:0]  coef_b2,
  input  logic signed [B_WIDTH-1:0]  coef_fb1,
  input  logic signed [B_WIDTH-1:0]  coef_fb2,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [A_WIDTH-1:0]  out_sample,
  output logic                       ovf
);

  localparam int ACC_W = A_WIDTH + B_WIDTH;

  state_t                    state;
  logic [2:0]                tap;
  logic signed [ACC_W-1:0]   acc;
  logic signed [ACC_W-1:0]   mac_sum;
  logic signed [A_WIDTH-1:0] x, x1, x2, y1, y2;
  logic signed [A_WIDTH-1:0] op_a;
  logic signed [B_WIDTH-1:0] op_b;
  logic signed [A_WIDTH-1:0] fmt_val;
  logic                      fmt_ovf;

  always_comb begin
    op_a = '0;
    op_b = '0;
    case (tap)
      TAP_B0:  begin op_a = x;  op_b = coef_b0;  end
      TAP_B1:  begin op_a = x1; op_b = coef_b1;  end
      TAP_B2:  begin op_a = x2; op_b = coef_b2;  end
      TAP_FB1: begin op_a = y1; op_b = coef_fb1; end
      TAP_FB2: begin op_a = y2; op_b = coef_fb2; end
      default: begin op_a = '0; op_b = '0;       end
    endcase
  end

  multaddsub_add_sign_7_6 #(
    .A_W (A_WIDTH),
    .B_W (B_WIDTH),
    .C_W (ACC_W)
  ) u_mac (
    .a   (op_a),
    .b   (op_b),
    .din (acc),
    .c   (mac_sum)
  );

`ifdef IIR_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(B_WIDTH+1){1'b0}}, {(A_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(B_WIDTH+1){1'b1}}, {(A_WIDTH-1){1'b0}}};

  logic signed [ACC_W-1:0] shifted;

  always_comb begin
    shifted = mac_sum >>> FRAC_SHIFT;
    fmt_val = shifted[A_WIDTH-1:0];
    fmt_ovf = 1'b0;
    if (shifted > SAT_MAX) begin
      fmt_val = SAT_MAX[A_WIDTH-1:0];
      fmt_ovf = 1'b1;
    end else if (shifted < SAT_MIN) begin
      fmt_val = SAT_MIN[A_WIDTH-1:0];
      fmt_ovf = 1'b1;
    end
  end
`else
  always_comb begin
    fmt_val = A_WIDTH'(mac_sum >>> FRAC_SHIFT);
    fmt_ovf = 1'b0;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      tap        <= '0;
      acc        <= '0;
      x          <= '0;
      x1         <= '0;
      x2         <= '0;
      y1         <= '0;
      y2         <= '0;
      out_sample <= '0;
      ovf        <= 1'b0;
      out_valid  <= 1'b0;
      in_ready   <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            x        <= in_sample;
            acc      <= '0;
            tap      <= TAP_B0;
            in_ready <= 1'b0;
            state    <= ST_MAC;
          end
        end
        ST_MAC: begin
          acc <= mac_sum;
          if (tap == TAP_FB2) begin
            // final tap: format the complete sum and advance the delay line
            out_sample <= fmt_val;
            ovf        <= fmt_ovf;
            out_valid  <= 1'b1;
            x2         <= x1;
            x1         <= x;
            y2         <= y1;
            y1         <= fmt_val;
            state      <= ST_OUT;
          end else begin
            tap <= tap + 3'd1;
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iir_biquad_seq.sv
// Scoreboard bench for iir_biquad_seq; honours IIR_SAT_EN like the design.
module tb_iir_biquad_seq;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic signed [6:0] in_sample;
  logic signed [5:0] b0, b1, b2, fb1, fb2;
  logic              out_valid;
  logic              out_ready;
  logic signed [6:0] out_sample;
  logic              ovf;

  int n_checks = 0;
  int n_errors = 0;
  int exp_q[$];
  int ovf_q[$];
  int mx1, mx2, my1, my2;

  always #5 clk = ~clk;

  iir_biquad_seq dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sample  (in_sample),
    .coef_b0    (b0),
    .coef_b1    (b1),
    .coef_b2    (b2),
    .coef_fb1   (fb1),
    .coef_fb2   (fb2),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sample (out_sample),
    .ovf        (ovf)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: full-precision sum, wrap to 13 bits, floor shift by 4, then format.
  task automatic model_push(input int xv);
    int s, y, o;
    logic signed [12:0] w, sh;
    s = int'(b0) * xv + int'(b1) * mx1 + int'(b2) * mx2 + int'(fb1) * my1 + int'(fb2) * my2;
    w = s[12:0];
    sh = w >>> 4;
`ifdef IIR_SAT_EN
    if (sh > 13'sd63) begin
      y = 63; o = 1;
    end else if (sh < -13'sd64) begin
      y = -64; o = 1;
    end else begin
      y = int'(sh); o = 0;
    end
`else
    y = int'($signed(sh[6:0]));
    o = 0;
`endif
    mx2 = mx1; mx1 = xv; my2 = my1; my1 = y;
    exp_q.push_back(y);
    ovf_q.push_back(o);
  endtask

  task automatic clear_model();
    mx1 = 0; mx2 = 0; my1 = 0; my2 = 0;
    exp_q.delete();
    ovf_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    clear_model();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_sample", out_sample, 0);
    chk("rst_ovf", ovf, 0);
  endtask

  task automatic set_coefs(input int c0, input int c1, input int c2, input int f1, input int f2);
    b0 = 6'(c0); b1 = 6'(c1); b2 = 6'(c2); fb1 = 6'(f1); fb2 = 6'(f2);
  endtask

  // Drive one sample, check latency and result, optionally stall the consumer.
  task automatic run_sample(input int xv, input int hold);
    int cnt, e_s, e_o;
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1);
    in_valid  = 1'b1;
    in_sample = 7'(xv);
    model_push(xv);
    @(posedge clk);
    #1 in_valid = 1'b0;
    cnt = 0;
    while (!out_valid && cnt < 20) begin
      @(posedge clk);
      #1 cnt++;
    end
    chk("latency", cnt, 5);
    e_s = exp_q.pop_front();
    e_o = ovf_q.pop_front();
    chk("out_sample", out_sample, e_s);
    chk("ovf", ovf, e_o);
    for (int i = 0; i < hold; i++) begin
      in_valid  = ~i[0];
      in_sample = 7'(i * 13 + 3);
      @(posedge clk);
      #1;
      chk("bp_stable", out_sample, e_s);
      chk("bp_ovf", ovf, e_o);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk("out_valid_drop", out_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_sample = '0;
    set_coefs(0, 0, 0, 0, 0);
    clear_model();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("init_out_valid", out_valid, 0);
    chk("init_in_ready", in_ready, 1);

    // impulse / unity gain
    do_reset();
    set_coefs(16, 0, 0, 0, 0);
    run_sample(5, 0);

    // first-order feedback decay, then a stalled output followed by a history check
    do_reset();
    set_coefs(16, 0, 0, 8, 0);
    run_sample(32, 0);
    run_sample(0, 0);
    run_sample(0, 0);
    run_sample(7, 10);
    run_sample(0, 0);

    // overflow: sum 1953, shifted 122
    do_reset();
    set_coefs(31, 0, 0, 0, 0);
    run_sample(63, 0);
    run_sample(-64, 0);

    // floor shift on negative values
    do_reset();
    set_coefs(1, 0, 0, 0, 0);
    run_sample(-1, 0);
    do_reset();
    set_coefs(16, 0, 0, 0, 0);
    run_sample(-3, 0);

    // reset in the middle of accumulation
    do_reset();
    set_coefs(16, 0, 0, 8, 0);
    run_sample(32, 0);
    @(negedge clk);
    in_valid  = 1'b1;
    in_sample = 7'sd32;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    clear_model();
    chk("midmac_out_valid", out_valid, 0);
    chk("midmac_in_ready", in_ready, 1);
    @(posedge clk);
    #1 chk("midmac_out_valid_hold", out_valid, 0);
    run_sample(5, 0);

    // random coefficients and samples through all five taps
    do_reset();
    for (int k = 0; k < 12; k++) begin
      set_coefs(int'($signed(6'($urandom_range(0, 63)))), int'($signed(6'($urandom_range(0, 63)))),
                int'($signed(6'($urandom_range(0, 63)))), int'($signed(6'($urandom_range(0, 63)))),
                int'($signed(6'($urandom_range(0, 63)))));
      run_sample(int'($signed(7'($urandom_range(0, 127)))), int'($urandom_range(0, 3)));
    end

    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
